// File: rtl/mul2b_mac_acc.sv
// Frame accumulator for mul2b products: sums 4-bit beats into an ACC_W result.
// Valid/ready on both sides, optional saturation, one registered result per frame.
module mul2b_mac_acc #(
    parameter int ACC_W     = 8,
    parameter int MAX_TERMS = 16,
    parameter int SATURATE  = 1,
    localparam int CNT_W    = $clog2(MAX_TERMS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m0,
    input  logic             m1,
    input  logic             m2,
    input  logic             m3,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] term_cnt,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W:0]   p_ext;
    logic [ACC_W:0]   sum;
    logic [CNT_W-1:0] cnt_inc;
    logic             fire;
    logic             closes;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        p_ext   = {{(ACC_W - 3){1'b0}}, m3, m2, m1, m0};
        sum     = {1'b0, acc_q} + p_ext;
        cnt_inc = cnt_q + CNT_W'(1);
        fire    = in_valid & in_ready;
        closes  = in_last | (cnt_inc == CNT_W'(MAX_TERMS));
    end

    // acc/cnt/ovf are left untouched in HOLD, which freezes the presented result
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (fire) begin
            cnt_d = cnt_inc;
            ovf_d = ovf_q | sum[ACC_W];
            if (sum[ACC_W] && (SATURATE != 0)) begin
                acc_d = '1;
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
        end else if ((state_q == HOLD) && out_ready) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, ACCUM: begin
                if (fire) begin
                    state_d = closes ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q != HOLD) & ~reset;
        out_valid = (state_q == HOLD);
        acc_out   = acc_q;
        term_cnt  = cnt_q;
        ovf       = ovf_q;
    end

endmodule

// File: tb/tb_mul2b_mac_acc.sv
// Bench for mul2b_mac_acc: three configurations driven in lockstep,
// checked every cycle against a frame-level arithmetic model.
module tb_mul2b_mac_acc;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] p_drv;
    logic       in_valid, in_last, out_ready;

    logic       rdy8, rdy5s, rdy5w;
    logic       vld8, vld5s, vld5w;
    logic [7:0] acc8;
    logic [4:0] acc5s, acc5w;
    logic [4:0] cnt8, cnt5s, cnt5w;
    logic       ovf8, ovf5s, ovf5w;

    int checks = 0;
    int errors = 0;

    // model state
    bit seen_rst = 1'b0;
    bit hold     = 1'b0;
    int tot      = 0;
    int cnt      = 0;

    always #5 clk = ~clk;

    mul2b_mac_acc u8 (
        .clk(clk), .reset(reset),
        .m0(p_drv[0]), .m1(p_drv[1]), .m2(p_drv[2]), .m3(p_drv[3]),
        .in_valid(in_valid), .in_last(in_last), .in_ready(rdy8),
        .acc_out(acc8), .term_cnt(cnt8), .ovf(ovf8),
        .out_valid(vld8), .out_ready(out_ready)
    );

    mul2b_mac_acc #(.ACC_W(5), .MAX_TERMS(16), .SATURATE(1)) u5s (
        .clk(clk), .reset(reset),
        .m0(p_drv[0]), .m1(p_drv[1]), .m2(p_drv[2]), .m3(p_drv[3]),
        .in_valid(in_valid), .in_last(in_last), .in_ready(rdy5s),
        .acc_out(acc5s), .term_cnt(cnt5s), .ovf(ovf5s),
        .out_valid(vld5s), .out_ready(out_ready)
    );

    mul2b_mac_acc #(.ACC_W(5), .MAX_TERMS(16), .SATURATE(0)) u5w (
        .clk(clk), .reset(reset),
        .m0(p_drv[0]), .m1(p_drv[1]), .m2(p_drv[2]), .m3(p_drv[3]),
        .in_valid(in_valid), .in_last(in_last), .in_ready(rdy5w),
        .acc_out(acc5w), .term_cnt(cnt5w), .ovf(ovf5w),
        .out_valid(vld5w), .out_ready(out_ready)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_acc(input int t, input int w, input bit sat);
        int lim;
        lim = 1 << w;
        if (t >= lim) return sat ? lim - 1 : t % lim;
        return t;
    endfunction

    function automatic int exp_ovf(input int t, input int w);
        return (t >= (1 << w)) ? 1 : 0;
    endfunction

    // frame-level model: collect accepted beats, close on last or 16th term
    always @(posedge clk) begin
        if (reset) begin
            seen_rst = 1'b1;
            hold = 1'b0;
            tot = 0;
            cnt = 0;
        end else if (hold) begin
            if (out_ready) begin
                hold = 1'b0;
                tot = 0;
                cnt = 0;
            end
        end else if (in_valid) begin
            tot += int'(p_drv);
            cnt++;
            if (in_last || cnt == 16) hold = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (seen_rst) begin
            chk("in_ready8", int'(rdy8), int'(!hold && !reset));
            chk("in_ready5s", int'(rdy5s), int'(!hold && !reset));
            chk("in_ready5w", int'(rdy5w), int'(!hold && !reset));
            chk("out_valid8", int'(vld8), int'(hold));
            chk("out_valid5s", int'(vld5s), int'(hold));
            chk("out_valid5w", int'(vld5w), int'(hold));
            if (hold) begin
                chk("acc8", int'(acc8), exp_acc(tot, 8, 1'b1));
                chk("cnt8", int'(cnt8), cnt);
                chk("ovf8", int'(ovf8), exp_ovf(tot, 8));
                chk("acc5s", int'(acc5s), exp_acc(tot, 5, 1'b1));
                chk("cnt5s", int'(cnt5s), cnt);
                chk("ovf5s", int'(ovf5s), exp_ovf(tot, 5));
                chk("acc5w", int'(acc5w), exp_acc(tot, 5, 1'b0));
                chk("cnt5w", int'(cnt5w), cnt);
                chk("ovf5w", int'(ovf5w), exp_ovf(tot, 5));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [3:0] p, input logic last);
        bit ok;
        p_drv = p;
        in_last = last;
        in_valid = 1'b1;
        #1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = rdy8;
            @(posedge clk);
            #2;
        end
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic chk_frame(input string tag, input int a8, input int a5s,
                             input int a5w, input int c, input int o8, input int o5);
        chk({tag, "_valid"}, int'(vld8), 1);
        chk({tag, "_acc8"}, int'(acc8), a8);
        chk({tag, "_cnt8"}, int'(cnt8), c);
        chk({tag, "_ovf8"}, int'(ovf8), o8);
        chk({tag, "_acc5s"}, int'(acc5s), a5s);
        chk({tag, "_ovf5s"}, int'(ovf5s), o5);
        chk({tag, "_acc5w"}, int'(acc5w), a5w);
        chk({tag, "_ovf5w"}, int'(ovf5w), o5);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b0;
        p_drv = 4'd0;
        step(2);
        chk("rst_in_ready", int'(rdy8), 0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(rdy8), 1);
        chk("post_rst_out_valid", int'(vld8), 0);
        chk("post_rst_acc", int'(acc8), 0);
        chk("post_rst_cnt", int'(cnt8), 0);
        chk("post_rst_ovf", int'(ovf8), 0);

        // four beats of 3*3 with the result held back for three cycles
        for (int i = 0; i < 4; i++) send(4'd9, i == 3);
        chk_frame("t1", 36, 31, 4, 4, 0, 1);
        step(3);
        chk("t5_acc_stable", int'(acc8), 36);
        chk("t5_in_ready", int'(rdy8), 0);
        out_ready = 1'b1;
        step(1);
        chk("t5_idle_valid", int'(vld8), 0);
        chk("t5_idle_ready", int'(rdy8), 1);

        // every a*b for 2-bit a, b
        for (int i = 0; i < 16; i++) begin
            logic [3:0] iv;
            iv = 4'(i);
            send(4'(iv[3:2] * iv[1:0]), i == 15);
        end
        chk_frame("t2", 36, 31, 4, 16, 0, 1);
        step(1);

        // auto close at 16 terms, then a 4-term frame
        for (int i = 0; i < 16; i++) send(4'd1, 1'b0);
        chk_frame("t4a", 16, 16, 16, 16, 0, 0);
        for (int i = 0; i < 4; i++) send(4'd1, i == 3);
        chk_frame("t4b", 4, 4, 4, 4, 0, 0);
        step(1);

        // abort a frame with reset
        send(4'd6, 1'b0);
        send(4'd6, 1'b0);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        send(4'd2, 1'b1);
        chk_frame("t6", 2, 2, 2, 1, 0, 0);
        step(1);

        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            p_drv = 4'($urandom);
            in_last = ($urandom_range(0, 5) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            step(1);
        end
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
